// File: rtl/tsn_tgm_pkg.sv
// Shared definitions for the traffic selection path: default widths,
// the token-bucket holdoff constant and the selector state encodings.
package tsn_tgm_pkg;

    localparam int QUEUE_NUM_DEF    = 8;
    localparam int QID_W_DEF        = 3;
    localparam int LEN_W_DEF        = 12;
    // Matches the consume/refresh/request pipeline depth of the token-bucket stage
    localparam int HOLDOFF_DEF      = 3;
    localparam int DONE_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        ISSUE_S = 2'd1,
        WAIT_S  = 2'd2
    } tsm_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at rr_ptr+1, rr_ptr+2, ...
// with wrap-around modulo QUEUE_NUM.
module rr_arbiter
    import tsn_tgm_pkg::*;
#(
    parameter int QUEUE_NUM = QUEUE_NUM_DEF,
    parameter int QID_W     = $clog2(QUEUE_NUM)
) (
    input  logic [QUEUE_NUM-1:0] req,
    input  logic [QID_W-1:0]     rr_ptr,
    output logic                 valid,
    output logic [QID_W-1:0]     winner
);

    always_comb begin : search
        logic [QID_W:0]   pos;
        logic [QID_W-1:0] idx;
        valid  = 1'b0;
        winner = '0;
        pos    = '0;
        idx    = '0;
        // Walk farthest-first so the nearest requester is the last assignment
        for (int i = QUEUE_NUM; i >= 1; i--) begin
            pos = {1'b0, rr_ptr} + (QID_W+1)'(i);
            if (pos >= (QID_W+1)'(QUEUE_NUM))
                pos = pos - (QID_W+1)'(QUEUE_NUM);
            idx = pos[QID_W-1:0];
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/tsm_rr_sel.sv
// Traffic selection: round-robin pick among token-bucket requests, descriptor
// handoff to the frame generator, then holdoff/done wait before re-arbitrating.
module tsm_rr_sel
    import tsn_tgm_pkg::*;
#(
    parameter int QUEUE_NUM    = QUEUE_NUM_DEF,
    parameter int QID_W        = QID_W_DEF,
    parameter int LEN_W        = LEN_W_DEF,
    parameter int HOLDOFF      = HOLDOFF_DEF,
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_tsm_enable,
    input  logic [QUEUE_NUM-1:0]       in_tsm_req,
    input  logic [QUEUE_NUM*LEN_W-1:0] in_tsm_pkt_len,
    output logic [QUEUE_NUM-1:0]       out_tsm_selected,
    output logic                       out_tsm_gen_valid,
    input  logic                       in_tsm_gen_ready,
    output logic [QID_W-1:0]           out_tsm_gen_qid,
    output logic [LEN_W-1:0]           out_tsm_gen_len,
    input  logic                       in_tsm_gen_done,
    output logic                       out_tsm_timeout_err
);

    localparam int HC_W = $clog2(HOLDOFF + 1);
    localparam int TO_W = $clog2(DONE_TIMEOUT);

    tsm_state_t           state_q, state_d;
    logic [QID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [QID_W-1:0]     qid_q, qid_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [HC_W-1:0]      hold_q, hold_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 done_seen_q, done_seen_d;
    logic                 valid_q, valid_d;
    logic [QUEUE_NUM-1:0] sel_q, sel_d;
    logic                 err_q, err_d;

    logic                 arb_valid;
    logic [QID_W-1:0]     win_qid;
    logic [LEN_W-1:0]     win_len;

    rr_arbiter #(
        .QUEUE_NUM (QUEUE_NUM),
        .QID_W     (QID_W)
    ) u_arb (
        .req    (in_tsm_req),
        .rr_ptr (rr_ptr_q),
        .valid  (arb_valid),
        .winner (win_qid)
    );

    // Constant-index mux keeps the length slice select width-clean
    always_comb begin
        win_len = '0;
        for (int i = 0; i < QUEUE_NUM; i++) begin
            if (win_qid == QID_W'(i))
                win_len = in_tsm_pkt_len[i*LEN_W +: LEN_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        qid_d       = qid_q;
        len_d       = len_q;
        hold_d      = hold_q;
        to_d        = to_q;
        done_seen_d = done_seen_q;
        valid_d     = valid_q;
        sel_d       = '0;
        err_d       = err_q;
        case (state_q)
            IDLE_S: begin
                if (in_tsm_enable && arb_valid) begin
                    qid_d   = win_qid;
                    len_d   = win_len;
                    state_d = ISSUE_S;
                end
            end
            ISSUE_S: begin
                if (valid_q && in_tsm_gen_ready) begin
                    valid_d     = 1'b0;
                    sel_d       = QUEUE_NUM'(1) << qid_q;
                    rr_ptr_d    = qid_q;
                    hold_d      = HC_W'(HOLDOFF);
                    to_d        = '0;
                    done_seen_d = 1'b0;
                    state_d     = WAIT_S;
                end else begin
                    valid_d = 1'b1;
                end
            end
            WAIT_S: begin
                if (hold_q != '0)
                    hold_d = hold_q - 1'b1;
                to_d = to_q + 1'b1;
                if (in_tsm_gen_done)
                    done_seen_d = 1'b1;
                if (done_seen_q && hold_q == '0) begin
                    done_seen_d = 1'b0;
                    state_d     = IDLE_S;
                end else if (!done_seen_q && to_q == TO_W'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE_S;
            rr_ptr_q    <= QID_W'(QUEUE_NUM - 1);
            qid_q       <= '0;
            len_q       <= '0;
            hold_q      <= '0;
            to_q        <= '0;
            done_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            sel_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            qid_q       <= qid_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            to_q        <= to_d;
            done_seen_q <= done_seen_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
        end
    end

    assign out_tsm_selected    = sel_q;
    assign out_tsm_gen_valid   = valid_q;
    assign out_tsm_gen_qid     = qid_q;
    assign out_tsm_gen_len     = len_q;
    assign out_tsm_timeout_err = err_q;

endmodule

// File: tb/tb_tsm_rr_sel.sv
// Directed bench for tsm_rr_sel: reset, round-robin order, wrap/skip,
// backpressure, holdoff vs. done timing, timeout and enable gating.
module tb_tsm_rr_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  req;
    logic [95:0] pkt_len;
    logic        ready;
    logic        done;
    logic [7:0]  sel;
    logic        valid;
    logic [2:0]  qid;
    logic [11:0] len;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tsm_rr_sel #(
        .QUEUE_NUM    (8),
        .QID_W        (3),
        .LEN_W        (12),
        .HOLDOFF      (3),
        .DONE_TIMEOUT (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_tsm_enable       (en),
        .in_tsm_req          (req),
        .in_tsm_pkt_len      (pkt_len),
        .out_tsm_selected    (sel),
        .out_tsm_gen_valid   (valid),
        .in_tsm_gen_ready    (ready),
        .out_tsm_gen_qid     (qid),
        .out_tsm_gen_len     (len),
        .in_tsm_gen_done     (done),
        .out_tsm_timeout_err (err)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_default_lens;
        for (int i = 0; i < 8; i++) pkt_len[i*12 +: 12] = 12'(64 + i);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    // One full grant with ready high; done pulsed dly cycles after the handshake edge.
    task automatic run_grant(input int dly, output bit ok, output logic [2:0] q,
                             output logic [11:0] l, output logic [7:0] s, output int nsel);
        wait_valid(40, ok);
        q = qid;
        l = len;
        tick;
        s = sel;
        nsel = (sel != 8'h00) ? 1 : 0;
        for (int i = 1; i < dly; i++) begin
            tick;
            if (sel != 8'h00) nsel++;
        end
        done = 1'b1;
        tick;
        done = 1'b0;
        if (sel != 8'h00) nsel++;
        repeat (2) begin
            tick;
            if (sel != 8'h00) nsel++;
        end
    endtask

    task automatic test_reset;
        en = 1'b1; req = 8'h00; ready = 1'b0; done = 1'b0;
        set_default_lens;
        do_reset;
        n_chk++; if (sel !== 8'h00) $display("FAIL reset_sel got %h want 00", sel); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_chk++; if (qid !== 3'd0) $display("FAIL reset_qid got %0d want 0", qid); else n_pass++;
        n_chk++; if (len !== 12'd0) $display("FAIL reset_len got %0d want 0", len); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
        repeat (4) tick;
        n_chk++; if (valid !== 1'b0) $display("FAIL idle_no_req_valid got %b want 0", valid); else n_pass++;
    endtask

    task automatic test_reset_mid_grant;
        bit ok;
        bit seen;
        logic [2:0] q; logic [11:0] l; logic [7:0] s; int nsel;
        do_reset;
        ready = 1'b1; req = 8'h01;
        run_grant(2, ok, q, l, s, nsel);
        n_chk++; if (!ok || q !== 3'd0) $display("FAIL mid_first_qid got %0d ok=%0d want 0", q, ok); else n_pass++;
        req = 8'hFF; ready = 1'b0;
        wait_valid(20, ok);
        n_chk++; if (!ok || qid !== 3'd1) $display("FAIL mid_issue_qid got %0d ok=%0d want 1", qid, ok); else n_pass++;
        rst = 1'b1; ready = 1'b1;
        tick;
        n_chk++;
        if (valid !== 1'b0 || sel !== 8'h00 || qid !== 3'd0 || len !== 12'd0 || err !== 1'b0)
            $display("FAIL mid_reset_outputs got valid=%b sel=%h qid=%0d len=%0d err=%b want all 0",
                     valid, sel, qid, len, err);
        else n_pass++;
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid === 1'b1) break;
            if (sel != 8'h00) seen = 1'b1;
            tick;
        end
        n_chk++; if (seen) $display("FAIL mid_no_stray_sel got a pulse want none"); else n_pass++;
        n_chk++; if (valid !== 1'b1 || qid !== 3'd0) $display("FAIL mid_regrant_qid got %0d valid=%b want 0", qid, valid); else n_pass++;
        tick;
        n_chk++; if (sel !== 8'h01) $display("FAIL mid_regrant_sel got %h want 01", sel); else n_pass++;
    endtask

    task automatic test_round_robin;
        bit ok;
        logic [2:0] q; logic [11:0] l; logic [7:0] s; int nsel;
        logic [2:0] exp_q;
        logic [7:0] exp_s;
        set_default_lens;
        do_reset;
        req = 8'hFF; ready = 1'b1;
        for (int g = 0; g < 9; g++) begin
            exp_q = 3'(g % 8);
            exp_s = 8'h01 << exp_q;
            run_grant(2, ok, q, l, s, nsel);
            n_chk++; if (!ok || q !== exp_q) $display("FAIL rr_qid[%0d] got %0d want %0d", g, q, exp_q); else n_pass++;
            n_chk++; if (l !== 12'(64 + int'(exp_q))) $display("FAIL rr_len[%0d] got %0d want %0d", g, l, 64 + int'(exp_q)); else n_pass++;
            n_chk++; if (s !== exp_s) $display("FAIL rr_sel[%0d] got %h want %h", g, s, exp_s); else n_pass++;
            n_chk++; if (nsel != 1) $display("FAIL rr_sel_width[%0d] got %0d cycles want 1", g, nsel); else n_pass++;
        end
    endtask

    task automatic test_wrap_skip;
        bit ok;
        logic [2:0] q; logic [11:0] l; logic [7:0] s; int nsel;
        set_default_lens;
        pkt_len[5*12 +: 12] = 12'd0;
        do_reset;
        ready = 1'b1; req = 8'h40;
        run_grant(2, ok, q, l, s, nsel);
        n_chk++; if (!ok || q !== 3'd6) $display("FAIL wrap_pre_qid got %0d want 6", q); else n_pass++;
        req = 8'b0010_0001;
        run_grant(2, ok, q, l, s, nsel);
        n_chk++; if (!ok || q !== 3'd0) $display("FAIL wrap_qid got %0d want 0", q); else n_pass++;
        run_grant(2, ok, q, l, s, nsel);
        n_chk++; if (!ok || q !== 3'd5) $display("FAIL skip_qid got %0d want 5", q); else n_pass++;
        n_chk++; if (l !== 12'd0) $display("FAIL zero_len got %0d want 0", l); else n_pass++;
        run_grant(2, ok, q, l, s, nsel);
        n_chk++; if (!ok || q !== 3'd0) $display("FAIL wrap_again_qid got %0d want 0", q); else n_pass++;
    endtask

    task automatic test_backpressure;
        bit ok;
        int stable;
        set_default_lens;
        pkt_len[2*12 +: 12] = 12'd1500;
        do_reset;
        ready = 1'b0; req = 8'h04;
        wait_valid(20, ok);
        n_chk++; if (!ok) $display("FAIL bp_valid_seen got none want valid"); else n_pass++;
        en = 1'b0;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid === 1'b1 && qid === 3'd2 && len === 12'd1500 && sel === 8'h00) stable++;
            tick;
        end
        n_chk++; if (stable != 10) $display("FAIL bp_hold got %0d stable cycles want 10", stable); else n_pass++;
        ready = 1'b1;
        tick;
        n_chk++; if (sel !== 8'h04) $display("FAIL bp_sel got %h want 04", sel); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL bp_valid_drop got %b want 0", valid); else n_pass++;
        tick;
        n_chk++; if (sel !== 8'h00) $display("FAIL bp_sel_width got %h want 00", sel); else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_holdoff;
        bit ok;
        int gap;
        set_default_lens;
        do_reset;
        en = 1'b1; ready = 1'b1; req = 8'h01;
        wait_valid(20, ok);
        tick;
        n_chk++; if (sel !== 8'h01) $display("FAIL ho_sel got %h want 01", sel); else n_pass++;
        done = 1'b1;
        tick;
        done = 1'b0;
        gap = 1;
        while (valid !== 1'b1 && gap < 30) begin
            tick;
            gap++;
        end
        n_chk++; if (gap != 6) $display("FAIL ho_early_done_gap got %0d want 6", gap); else n_pass++;
        n_chk++; if (qid !== 3'd0) $display("FAIL ho_rewin_qid got %0d want 0", qid); else n_pass++;
        tick;
        n_chk++; if (sel !== 8'h01) $display("FAIL ho_rewin_sel got %h want 01", sel); else n_pass++;
        gap = 0;
        repeat (5) begin
            tick;
            gap++;
        end
        done = 1'b1;
        tick;
        gap++;
        done = 1'b0;
        while (valid !== 1'b1 && gap < 40) begin
            tick;
            gap++;
        end
        n_chk++; if (gap != 9) $display("FAIL ho_late_done_gap got %0d want 9", gap); else n_pass++;
    endtask

    task automatic test_timeout;
        bit ok;
        bit seen;
        set_default_lens;
        do_reset;
        en = 1'b1; ready = 1'b0; req = 8'h01;
        wait_valid(20, ok);
        done = 1'b1;
        tick;
        done = 1'b0;
        ready = 1'b1;
        tick;
        n_chk++; if (!ok || sel !== 8'h01) $display("FAIL to_sel got %h want 01", sel); else n_pass++;
        repeat (15) tick;
        n_chk++; if (err !== 1'b0) $display("FAIL to_err_early got %b want 0", err); else n_pass++;
        tick;
        n_chk++; if (err !== 1'b1) $display("FAIL to_err_set got %b want 1", err); else n_pass++;
        en = 1'b0; req = 8'hFF;
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (valid !== 1'b0) seen = 1'b1;
        end
        n_chk++; if (seen) $display("FAIL to_disabled_valid got valid want none"); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL to_err_sticky got %b want 1", err); else n_pass++;
        en = 1'b1;
        wait_valid(20, ok);
        n_chk++; if (!ok || qid !== 3'd1) $display("FAIL to_recover_qid got %0d ok=%0d want 1", qid, ok); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL to_err_sticky2 got %b want 1", err); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; ready = 1'b0; done = 1'b0; pkt_len = '0;
        test_reset;
        test_reset_mid_grant;
        test_round_robin;
        test_wrap_skip;
        test_backpressure;
        test_holdoff;
        test_timeout;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
